// File: rtl/mgt01_mul_scheduler.sv
// Round-robin front end for the shared iterative Booth radix-4 multiplier.
// Launches one op, gates the multiplier clock enable, returns the result.
module mgt01_mul_scheduler #(
  parameter int XLEN     = 32,
  parameter int NREQ     = 2,
  parameter int MUL_ITER = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [NREQ*XLEN-1:0] req_a_i,
  input  logic [NREQ*XLEN-1:0] req_b_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  input  logic [NREQ-1:0]   rsp_ready_i,
  output logic [XLEN-1:0]   rsp_result_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [XLEN-1:0]   mul_multiplier_o,
  output logic [XLEN-1:0]   mul_multiplicand_o,
  output logic              mul_clk_en_o,
  input  logic [XLEN-1:0]   mul_result_i,
  input  logic              mul_valid_i
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MUL_ITER + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, r_owner;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_result;
  logic            r_err, w_err_nxt;
  logic            w_launch, w_cap, w_clk_en;

  logic [2*NREQ-1:0] w_dbl;
  logic [PW-1:0]     w_off, w_gnt, w_ptr_nxt;
  logic [PW:0]       w_sum, w_p1;
  logic [XLEN-1:0]   w_a, w_b;

  // rotate valids so bit 0 is the requester at the pointer
  assign w_dbl = {req_valid_i, req_valid_i} >> r_ptr;

  // lowest set rotated bit wins, mapped back to a requester index
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_dbl[i]) w_off = PW'(i);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (PW+1)'(NREQ)) w_gnt = PW'(w_sum - (PW+1)'(NREQ));
    else                        w_gnt = w_sum[PW-1:0];
    w_p1 = {1'b0, w_gnt} + (PW+1)'(1);
    if (w_p1 == (PW+1)'(NREQ)) w_ptr_nxt = '0;
    else                       w_ptr_nxt = w_p1[PW-1:0];
  end

  // operand mux for the granted requester
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int n = 0; n < NREQ; n++) begin
      if (w_gnt == PW'(n)) begin
        w_a = req_a_i[n*XLEN +: XLEN];
        w_b = req_b_i[n*XLEN +: XLEN];
      end
    end
  end

  // next state, iteration watchdog and multiplier clock enable
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_launch    = 1'b0;
    w_cap       = 1'b0;
    w_clk_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mul_valid_i && !flush_i && |req_valid_i) begin
          w_launch    = 1'b1;
          w_clk_en    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_clk_en = ~mul_valid_i;
        if (!mul_valid_i) w_cnt_nxt = r_cnt + CW'(1);
        if (flush_i) begin
          w_state_nxt = S_DRAIN;
        end else if (mul_valid_i) begin
          w_cap       = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_cnt_nxt == CW'(MUL_ITER + 1)) begin
          w_err_nxt   = 1'b1;
          w_cap       = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (flush_i || rsp_ready_i[r_owner]) w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        w_clk_en = ~mul_valid_i;
        if (mul_valid_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state, pointer, owner, counter, result and sticky error
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      if (w_launch) begin
        r_ptr   <= w_ptr_nxt;
        r_owner <= w_gnt;
      end
      if (w_cap) r_result <= mul_result_i;
    end
  end

  assign req_ready_o        = NREQ'(w_launch) << w_gnt;
  assign mul_multiplier_o   = w_launch ? w_a : '0;
  assign mul_multiplicand_o = w_launch ? w_b : '0;
  assign mul_clk_en_o       = w_clk_en;
  assign rsp_valid_o        = NREQ'(r_state == S_RESP) << r_owner;
  assign rsp_result_o       = (r_state == S_RESP) ? r_result : '0;
  assign busy_o             = (r_state != S_IDLE);
  assign err_o              = r_err;

  a_rdy_oh: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    $onehot0(req_ready_o));
  a_rsp_oh: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    $onehot0(rsp_valid_o));

  for (genvar n = 0; n < NREQ; n++) begin : g_hold
    a_hold: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      (req_valid_i[n] && !req_ready_o[n]) |=>
      (req_valid_i[n] &&
       $stable(req_a_i[n*XLEN +: XLEN]) &&
       $stable(req_b_i[n*XLEN +: XLEN])));
  end

endmodule
